// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control ahead of a byte-addressed data memory; define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
// Latency: response valid two cycles after accept (one on fault); resp_ready low holds RESP and keeps req_ready low.
module lsu_ctrl #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DMEM_BYTES  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_store,
  input  logic [2:0]             req_funct3,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  logic [4:0]             req_rd,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [WORD_LENGTH-1:0] mem_write_data,
  output logic [2:0]             mem_write_enable,
  output logic                   mem_read_enable,
  input  logic [WORD_LENGTH-1:0] mem_data_in,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_LENGTH-1:0] resp_data,
  output logic [4:0]             resp_rd,
  output logic                   resp_err
);

  localparam int AW1 = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state, state_nxt;
  logic                   store_q;
  logic [2:0]             funct3_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  logic [WORD_LENGTH-1:0] data_q;
  logic [4:0]             rd_q;
  logic                   err_q;

  logic [2:0]             req_size;
  logic [AW1-1:0]         req_end;
  logic                   funct3_ok;
  logic                   range_ok;
  logic                   align_ok;
  logic                   req_fault;
  logic [2:0]             we_pat;
  logic [WORD_LENGTH-1:0] load_ext;
  logic                   exec_active;
  logic                   resp_active;

  // Request legality, evaluated on the live request while IDLE.
  always_comb begin
    req_size  = 3'd4;
    funct3_ok = 1'b0;
    align_ok  = 1'b1;
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !req_store;
      default:                funct3_ok = 1'b0;
    endcase
    // Extra top bit keeps addresses near the top of the space from wrapping.
    req_end  = {1'b0, req_addr} + AW1'(req_size);
    range_ok = (req_end <= AW1'(DMEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   align_ok = !req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
`else
    align_ok = 1'b1;
`endif
    req_fault = !(funct3_ok && range_ok && align_ok);
  end

  always_comb begin
    we_pat = 3'b000;
    case (funct3_q[1:0])
      2'b00:   we_pat = 3'b001;
      2'b01:   we_pat = 3'b011;
      2'b10:   we_pat = 3'b111;
      default: we_pat = 3'b000;
    endcase
  end

  always_comb begin
    load_ext = mem_data_in;
    case (funct3_q)
      3'b000:  load_ext = {{(WORD_LENGTH-8){mem_data_in[7]}}, mem_data_in[7:0]};
      3'b001:  load_ext = {{(WORD_LENGTH-16){mem_data_in[15]}}, mem_data_in[15:0]};
      3'b100:  load_ext = {{(WORD_LENGTH-8){1'b0}}, mem_data_in[7:0]};
      3'b101:  load_ext = {{(WORD_LENGTH-16){1'b0}}, mem_data_in[15:0]};
      default: load_ext = mem_data_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_fault ? RESP : EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      rd_q     <= 5'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
            err_q    <= req_fault;
            data_q   <= '0;
          end
        end
        EXEC: begin
          if (!store_q) begin
            data_q <= load_ext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Every output is gated by rst so reset silences the memory port immediately.
  assign exec_active      = rst && (state == EXEC);
  assign resp_active      = rst && (state == RESP);
  assign req_ready        = rst && (state == IDLE);
  assign mem_address      = exec_active ? addr_q : '0;
  assign mem_write_data   = (exec_active && store_q) ? wdata_q : '0;
  assign mem_write_enable = (exec_active && store_q) ? we_pat : 3'b000;
  assign mem_read_enable  = exec_active && !store_q;
  assign resp_valid       = resp_active;
  assign resp_data        = resp_active ? data_q : '0;
  assign resp_rd          = resp_active ? rd_q : 5'd0;
  assign resp_err         = resp_active && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of directed transactions against a 32-byte memory model, plus stall and reset sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_data_in;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  logic        mem_clr;
  logic [7:0]  mem [0:31];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.WORD_LENGTH(32), .ADDR_WIDTH(32), .DMEM_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_in(mem_data_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  // Little-endian byte memory: combinational read, write on the rising edge.
  always @(posedge clk) begin : mem_wr
    int nb;
    nb = (mem_write_enable == 3'b001) ? 1 : (mem_write_enable == 3'b011) ? 2 :
         (mem_write_enable == 3'b111) ? 4 : 0;
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (rst) begin
      for (int i = 0; i < 4; i++)
        if (i < nb && (mem_address + 32'(i)) < 32'd32)
          mem[5'(mem_address + 32'(i))] <= mem_write_data[8*i +: 8];
    end
  end

  always_comb begin
    mem_data_in = 32'h0;
    for (int i = 0; i < 4; i++)
      if ((mem_address + 32'(i)) < 32'd32)
        mem_data_in[8*i +: 8] = mem[5'(mem_address + 32'(i))];
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [2:0]  we;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] d, input logic e, input logic [2:0] we);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rd = rd;
    v.data = d; v.err = e; v.we = we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic wait_ready(input string nm, output logic ok);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1; req_store = v.st; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
  endtask

  task automatic run(input vec_t v, input string nm);
    logic ok;
    @(negedge clk);
    wait_ready(nm, ok);
    if (ok) begin
      drive(v);
      @(negedge clk);
      req_valid = 1'b0;
      if (!v.err) begin
        chk({nm, "_exec_we"}, 32'(mem_write_enable), 32'(v.we));
        chk({nm, "_exec_re"}, 32'(mem_read_enable), 32'(!v.st));
        chk({nm, "_exec_addr"}, mem_address, v.addr);
        if (v.st) chk({nm, "_exec_wdata"}, mem_write_data, v.wdata);
        chk({nm, "_exec_valid"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
      end
      chk({nm, "_resp_we"}, 32'(mem_write_enable), 32'd0);
      chk({nm, "_resp_re"}, 32'(mem_read_enable), 32'd0);
      chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_resp_err"}, 32'(resp_err), 32'(v.err));
      chk({nm, "_resp_data"}, resp_data, v.data);
      chk({nm, "_resp_rd"}, 32'(resp_rd), 32'(v.rd));
      chk({nm, "_resp_req_ready"}, 32'(req_ready), 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({nm, "_done_valid"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic ok;
    vec_t v;
    //           st    f3      addr          wdata         rd     data          err   we
    vt[0]  = mk(1'b1, 3'b010, 32'h08,       32'hDEADBEEF, 5'd1,  32'h0,        1'b0, 3'b111);
    vt[1]  = mk(1'b0, 3'b010, 32'h08,       32'h0,        5'd5,  32'hDEADBEEF, 1'b0, 3'b000);
    vt[2]  = mk(1'b1, 3'b000, 32'h04,       32'h00000080, 5'd2,  32'h0,        1'b0, 3'b001);
    vt[3]  = mk(1'b0, 3'b000, 32'h04,       32'h0,        5'd6,  32'hFFFFFF80, 1'b0, 3'b000);
    vt[4]  = mk(1'b0, 3'b100, 32'h04,       32'h0,        5'd7,  32'h00000080, 1'b0, 3'b000);
    vt[5]  = mk(1'b1, 3'b001, 32'h0C,       32'h00008001, 5'd3,  32'h0,        1'b0, 3'b011);
    vt[6]  = mk(1'b0, 3'b001, 32'h0C,       32'h0,        5'd8,  32'hFFFF8001, 1'b0, 3'b000);
    vt[7]  = mk(1'b0, 3'b101, 32'h0C,       32'h0,        5'd9,  32'h00008001, 1'b0, 3'b000);
    vt[8]  = mk(1'b0, 3'b010, 32'h1E,       32'h0,        5'd10, 32'h0,        1'b1, 3'b000);
    vt[9]  = mk(1'b0, 3'b011, 32'h00,       32'h0,        5'd11, 32'h0,        1'b1, 3'b000);
`ifdef LSU_MISALIGN_TRAP_EN
    vt[10] = mk(1'b0, 3'b010, 32'h01,       32'h0,        5'd12, 32'h0,        1'b1, 3'b000);
`else
    vt[10] = mk(1'b0, 3'b010, 32'h01,       32'h0,        5'd12, 32'h80000000, 1'b0, 3'b000);
`endif
    vt[11] = mk(1'b1, 3'b100, 32'h00,       32'h11,       5'd13, 32'h0,        1'b1, 3'b000);
    vt[12] = mk(1'b1, 3'b010, 32'h1C,       32'h12345678, 5'd14, 32'h0,        1'b0, 3'b111);
    vt[13] = mk(1'b0, 3'b010, 32'h1C,       32'h0,        5'd15, 32'h12345678, 1'b0, 3'b000);
    vt[14] = mk(1'b0, 3'b000, 32'h1F,       32'h0,        5'd16, 32'h00000012, 1'b0, 3'b000);
    vt[15] = mk(1'b0, 3'b001, 32'h1E,       32'h0,        5'd17, 32'h00001234, 1'b0, 3'b000);
    vt[16] = mk(1'b0, 3'b001, 32'h1F,       32'h0,        5'd18, 32'h0,        1'b1, 3'b000);
    vt[17] = mk(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        5'd19, 32'h0,        1'b1, 3'b000);
    vt[18] = mk(1'b1, 3'b010, 32'h20,       32'hFFFFFFFF, 5'd20, 32'h0,        1'b1, 3'b000);

    rst = 1'b0; mem_clr = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst_mem_re", 32'(mem_read_enable), 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    rst = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 19; i++) run(vt[i], $sformatf("v%0d", i));

    // Response back-pressure: five stalled cycles must leave RESP untouched.
    @(negedge clk);
    wait_ready("stall", ok);
    if (ok) begin
      v = mk(1'b0, 3'b010, 32'h08, 32'h0, 5'd21, 32'hDEADBEEF, 1'b0, 3'b000);
      drive(v);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("stall%0d_valid", c), 32'(resp_valid), 32'd1);
        chk($sformatf("stall%0d_data", c), resp_data, 32'hDEADBEEF);
        chk($sformatf("stall%0d_rd", c), 32'(resp_rd), 32'd21);
        chk($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'd0);
        chk($sformatf("stall%0d_re", c), 32'(mem_read_enable), 32'd0);
        @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("stall_done_valid", 32'(resp_valid), 32'd0);
    end

    // Reset asserted while a store sits in EXEC: no commit, no response.
    @(negedge clk);
    wait_ready("rstexec", ok);
    if (ok) begin
      v = mk(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 5'd22, 32'h0, 1'b0, 3'b111);
      drive(v);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstexec_pre_we", 32'(mem_write_enable), 32'd7);
      rst = 1'b0;
      #1;
      chk("rstexec_we", 32'(mem_write_enable), 32'd0);
      chk("rstexec_wdata", mem_write_data, 32'd0);
      @(negedge clk);
      chk("rstexec_valid", 32'(resp_valid), 32'd0);
      chk("rstexec_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rstexec_idle_ready", 32'(req_ready), 32'd1);
      chk("rstexec_idle_valid", 32'(resp_valid), 32'd0);
    end
    run(mk(1'b0, 3'b010, 32'h10, 32'h0, 5'd23, 32'h0, 1'b0, 3'b000), "rstexec_load");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
